sd_sector_loader: RTL and testbench

Sector-load controller sitting directly upstream of the dual-port SD sector buffer RAM. It accepts a sector request (LBA) from the core, runs the `sd_rd`/`sd_ack` handshake toward the HPS SD interface, and writes the streamed bytes into RAM port A. Sectors are written into rotating banks, so the consumer can read bank N on port B while bank N+1 fills. It reports completion, the bank just filled, and protocol errors.

---
 rtl/sd_sector_loader.sv | 109 ++++++++++
 tb/tb_sd_sector_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_loader.sv
// Sector-load controller: runs the sd_rd/sd_ack handshake with the HPS and writes
// streamed sector bytes into rotating banks of the port-A sector buffer RAM.
module sd_sector_loader #(
    parameter int addr_width     = 10,
    parameter int timeout_cycles = 1048575
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [31:0]           req_lba,
    output logic                  req_ready,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    input  logic                  sd_ack,
    input  logic [8:0]            sd_buff_addr,
    input  logic [7:0]            sd_buff_dout,
    input  logic                  sd_buff_wr,
    output logic                  ram_wren,
    output logic [addr_width-1:0] ram_address,
    output logic [7:0]            ram_data,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-10:0] done_bank,
    output logic                  err
);

    localparam int bank_w = addr_width - 9;
    localparam int tmo_w  = $clog2(timeout_cycles + 1);
    localparam logic [tmo_w-1:0] tmo_last = tmo_w'(timeout_cycles - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, FIN} state_t;

    state_t            state, state_nxt;
    logic [bank_w-1:0] bank;
    logic [9:0]        byte_cnt;
    logic [tmo_w-1:0]  tmo_cnt;
    logic              wr_hit;
    logic              tmo_hit;
    logic              good_cnt;

    // Strobes only count while the HPS still holds sd_ack; ack beats a same-cycle timeout.
    assign wr_hit   = (state == XFER) && sd_buff_wr && sd_ack;
    assign tmo_hit  = (state == REQ) && !sd_ack && (tmo_cnt == tmo_last);
    assign good_cnt = (byte_cnt == 10'd512);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = REQ;
            REQ:     if (sd_ack) state_nxt = XFER;
                     else if (tmo_hit) state_nxt = IDLE;
            XFER:    if (!sd_ack) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        sd_rd     = (state == REQ);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sd_lba      <= '0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            done        <= 1'b0;
            done_bank   <= '0;
            err         <= 1'b0;
            bank        <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            ram_wren <= wr_hit;
            done     <= 1'b0;
            err      <= tmo_hit;
            if (wr_hit) begin
                ram_address <= {bank, sd_buff_addr};
                ram_data    <= sd_buff_dout;
                if (byte_cnt != 10'h3FF) byte_cnt <= byte_cnt + 10'd1;
            end
            // done/err are registered on the ack-drop edge so they land in the FIN cycle.
            case (state)
                IDLE: if (req_valid) begin
                    sd_lba   <= req_lba;
                    byte_cnt <= '0;
                    tmo_cnt  <= '0;
                end
                REQ:  tmo_cnt <= tmo_cnt + 1'b1;
                XFER: if (!sd_ack) begin
                    done <= good_cnt;
                    err  <= !good_cnt;
                    if (good_cnt) done_bank <= bank;
                end
                FIN:  if (good_cnt) bank <= bank + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_loader.sv
// Directed/randomized bench for sd_sector_loader with a transaction-level model of
// bank rotation and the expected RAM write stream.
module tb_sd_sector_loader;

    localparam int AW    = 10;
    localparam int NBANK = 1 << (AW - 9);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [31:0]   req_lba = '0;
    logic          req_ready;
    logic [31:0]   sd_lba;
    logic          sd_rd;
    logic          sd_ack = 1'b0;
    logic [8:0]    sd_buff_addr = '0;
    logic [7:0]    sd_buff_dout = '0;
    logic          sd_buff_wr = 1'b0;
    logic          ram_wren;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          busy;
    logic          done;
    logic [AW-10:0] done_bank;
    logic          err;

    int checks = 0;
    int errors = 0;
    int bank_m = 0;
    int rd_rises = 0;
    logic sd_rd_prev = 1'b0;
    logic [AW+7:0] got_q[$];
    logic [AW+7:0] exp_q[$];

    sd_sector_loader #(.addr_width(AW), .timeout_cycles(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_lba(req_lba), .req_ready(req_ready),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data),
        .busy(busy), .done(done), .done_bank(done_bank), .err(err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ram_wren === 1'b1) got_q.push_back({ram_address, ram_data});
        if (sd_rd === 1'b1 && sd_rd_prev !== 1'b1) rd_rises++;
        sd_rd_prev = sd_rd;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_writes(input string tag);
        int bad;
        int n;
        bad = 0;
        check({tag, "_wr_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({tag, "_wr_content"}, bad, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic stream_bytes(input int nbytes, input bit seq);
        logic [8:0] a;
        logic [7:0] d;
        logic [AW-1:0] ea;
        for (int i = 0; i < nbytes; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            a  = seq ? 9'(i) : 9'($urandom_range(0, 511));
            d  = seq ? 8'(i) : 8'($urandom);
            ea = AW'(bank_m * 512 + int'(a));
            sd_buff_addr = a;
            sd_buff_dout = d;
            sd_buff_wr   = 1'b1;
            exp_q.push_back({ea, d});
            @(negedge clock);
            sd_buff_wr = 1'b0;
        end
    endtask

    task automatic run_load(input string tag, input logic [31:0] lba, input int ack_delay,
                            input int nbytes, input bit seq, input bit hold_req);
        int rises0;
        bit good;
        rises0 = rd_rises;
        good = (nbytes == 512);
        check({tag, "_ready_idle"}, req_ready, 1);
        req_valid = 1'b1;
        req_lba   = lba;
        @(negedge clock);
        if (hold_req) req_lba = ~lba;
        else          req_valid = 1'b0;
        check({tag, "_rd_accept"}, sd_rd, 1);
        check({tag, "_busy_accept"}, busy, 1);
        check({tag, "_sd_lba"}, sd_lba, lba);
        for (int i = 0; i < ack_delay; i++) begin
            sd_buff_wr   = 1'b1;
            sd_buff_addr = 9'($urandom);
            sd_buff_dout = 8'($urandom);
            @(negedge clock);
            sd_buff_wr = 1'b0;
        end
        sd_ack = 1'b1;
        @(negedge clock);
        check({tag, "_rd_drop"}, sd_rd, 0);
        stream_bytes(nbytes, seq);
        sd_ack    = 1'b0;
        req_valid = 1'b0;
        if (hold_req) begin
            sd_buff_wr   = 1'b1;
            sd_buff_addr = 9'($urandom);
        end
        @(negedge clock);
        sd_buff_wr = 1'b0;
        check({tag, "_done"}, done, good);
        check({tag, "_err"}, err, !good);
        if (good) begin
            check({tag, "_done_bank"}, done_bank, bank_m);
            bank_m = (bank_m + 1) % NBANK;
        end
        @(negedge clock);
        check({tag, "_ready_after"}, req_ready, 1);
        check({tag, "_pulse_end"}, {done, err}, 2'b00);
        check({tag, "_rd_rises"}, rd_rises - rises0, 1);
        check({tag, "_lba_held"}, sd_lba, lba);
        compare_writes(tag);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_ready", req_ready, 1);
        check("rst_rd", sd_rd, 0);
        check("rst_lba", sd_lba, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_addr", ram_address, 0);
        check("rst_data", ram_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bank", done_bank, 0);
        check("rst_err", err, 0);

        run_load("normal", 32'h0000_1234, 3, 512, 1'b1, 1'b0);
        run_load("second", $urandom, $urandom_range(0, 8), 512, 1'b0, 1'b0);
        run_load("wrap", $urandom, $urandom_range(0, 8), 512, 1'b1, 1'b0);
        run_load("short", $urandom, $urandom_range(0, 8), 300, 1'b0, 1'b0);
        run_load("hold", $urandom, $urandom_range(1, 8), 512, 1'b0, 1'b1);

        check("tmo_ready", req_ready, 1);
        req_valid = 1'b1;
        req_lba   = $urandom;
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (sd_rd === 1'b1 && n < 40) begin
            n++;
            @(negedge clock);
        end
        check("tmo_rd_cycles", n, 16);
        check("tmo_err", err, 1);
        check("tmo_ready_after", req_ready, 1);
        check("tmo_busy", busy, 0);
        @(negedge clock);
        check("tmo_err_pulse", err, 0);
        compare_writes("tmo");

        run_load("long", $urandom, $urandom_range(0, 8), 520, 1'b0, 1'b0);
        run_load("post_err", $urandom, $urandom_range(0, 8), 512, 1'b0, 1'b0);

        req_valid = 1'b1;
        req_lba   = $urandom;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        sd_ack = 1'b1;
        @(negedge clock);
        stream_bytes(100, 1'b0);
        sd_buff_wr = 1'b1;
        reset      = 1'b1;
        @(negedge clock);
        sd_buff_wr = 1'b0;
        check("mrst_rd", sd_rd, 0);
        check("mrst_wren", ram_wren, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", req_ready, 1);
        check("mrst_lba", sd_lba, 0);
        reset  = 1'b0;
        sd_ack = 1'b0;
        bank_m = 0;
        @(negedge clock);
        got_q.delete();
        exp_q.delete();
        run_load("after_rst", $urandom, $urandom_range(0, 8), 512, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
